hazard_stall_controller: RTL and testbench
==========================================

# hazard_stall_controller

Pipeline sequencing controller for the 5-stage MIPS core, sitting beside the forwarding unit in the hazard/forwarding group. It detects hazards that forwarding cannot cover (load-use, branch-in-ID operand dependencies, multi-cycle multiply/divide occupancy) and drives the PC/IF-ID stall, ID-EX bubble and IF-ID flush controls. It owns the multiply/divide unit (MDU) occupancy state machine and a saturating stall-cycle performance counter.

## Interface
- LEN_REG_FILE_ADDR, 5, register-file address width
- MDU_LATENCY, 4, MDU busy cycles per operation; legal range 1..2^LEN_MDU_CNT-1
- LEN_MDU_CNT, 6, MDU countdown counter width

- clk  in  1  clock, all state on rising edge
- reset  in  1  reset, synchronous, active-high
- reg_1_id, reg_2_id  in  LEN_REG_FILE_ADDR  source registers of ID instruction
- uses_reg_1_id, uses_reg_2_id  in  1  ID instruction actually reads that source
- branch_id  in  1  ID holds a branch resolved in ID
- taken_id  in  1  ID branch resolves taken
- mdu_op_id  in  1  ID holds mult/div
- mdu_read_id  in  1  ID holds mfhi/mflo
- reg_3_ex, reg_write_ex, mem_read_ex  in  LEN/1/1  EX destination, write enable, load flag
- reg_3_m, mem_read_m  in  LEN/1  M destination, load flag
- stall_pc  out  1  hold PC
- stall_if_id  out  1  hold IF/ID register
- bubble_id_ex  out  1  load NOP into ID/EX
- flush_if_id  out  1  squash IF/ID (taken branch)
- mdu_start  out  1  launch MDU operation this cycle
- mdu_busy  out  1  MDU occupied
- stall_cycles  out  32  saturating count of stall cycles

## Operation
- match_x(r) = r != 0 && ((uses_reg_1_id && r == reg_1_id) || (uses_reg_2_id && r == reg_2_id)).
- Hazard terms:
  - load_use = mem_read_ex && match_x(reg_3_ex).
  - br_ex = branch_id && reg_write_ex && match_x(reg_3_ex) (covers loads in EX too).
  - br_load_m = branch_id && mem_read_m && match_x(reg_3_m).
  - mdu_hz = mdu_busy && (mdu_op_id || mdu_read_id).
- stall = load_use || br_ex || br_load_m || mdu_hz.
- stall_pc = stall_if_id = bubble_id_ex = stall.
- flush_if_id = branch_id && taken_id && !stall; taken_id ignored while stalling (branch re-evaluated next cycle).
- mdu_start = mdu_op_id && !stall.
- Branch on load in EX: stalls 2 cycles naturally (br_ex, then br_load_m); branch on ALU result in EX: 1 cycle, then M->ID forwarding.
- MDU FSM, states IDLE (cnt==0) and BUSY (cnt!=0):
  - IDLE -> BUSY on mdu_start: cnt <= MDU_LATENCY.
  - BUSY: cnt decrements each cycle; BUSY -> IDLE when cnt goes 1 -> 0.
  - mdu_start cannot occur in BUSY when mdu_op_id is set (mdu_hz stalls it); back-to-back op issues the cycle cnt reads 0.
  - mdu_busy = (cnt != 0).
- stall_cycles increments by 1 on each cycle with stall=1; holds at 32'hFFFF_FFFF.
- Priority: any stall term suppresses flush_if_id and mdu_start; simultaneous terms count as one stall cycle.

## Timing
- Reset (sync): cnt <= 0 (IDLE), stall_cycles <= 0. While reset high, all combinational outputs forced 0. Reset mid-MDU-operation aborts it; mdu_busy is 0 the cycle after reset deasserts.
- stall_pc, stall_if_id, bubble_id_ex, flush_if_id, mdu_start: combinational, same cycle as inputs.
- mdu_busy: function of registered cnt. mdu_start in cycle T -> mdu_busy high in T+1..T+MDU_LATENCY, low in T+MDU_LATENCY+1.
- mfhi/mflo in ID during busy stalls; issues in T+MDU_LATENCY+1.
- stall_cycles: registered, reflects stall of cycle T in T+1.

## Test plan
- Load-use: mem_read_ex=1, reg_3_ex=5, reg_1_id=5, uses_reg_1_id=1 -> stall_pc=stall_if_id=bubble_id_ex=1 one cycle; stall_cycles 0->1.
- Zero register: same as above with reg_3_ex=0 -> no stall; flush_if_id follows branch_id && taken_id.
- Branch on load: branch_id=1, taken_id=1, load to r8 in EX, reg_2_id=8 -> stall 2 cycles (EX then M), flush_if_id=0 during both, flush_if_id=1 on third cycle.
- MDU occupancy (MDU_LATENCY=4): mult in ID at T -> mdu_start=1 at T, mdu_busy T+1..T+4; mflo in ID at T+1 -> stalls T+1..T+4, issues T+5; stall_cycles +4.
- Reset mid-op: assert reset at T+2 after mdu_start -> outputs 0 during reset, cnt=0, mdu_busy=0, stall_cycles=0 after deassert; next mult starts immediately.
- Saturation: preload stall_cycles near max via sustained stall -> holds at 32'hFFFF_FFFF, no wrap.

Source files
------------

// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - load-use/branch/MDU hazard detection, stall/flush control, MDU occupancy FSM, stall counter
module hazard_stall_controller #(
  parameter int LEN_REG_FILE_ADDR = 5,
  parameter int MDU_LATENCY       = 4,
  parameter int LEN_MDU_CNT       = 6,
  parameter int LEN_STALL_CNT     = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [LEN_REG_FILE_ADDR-1:0] reg_1_id,
  input  logic [LEN_REG_FILE_ADDR-1:0] reg_2_id,
  input  logic                         uses_reg_1_id,
  input  logic                         uses_reg_2_id,
  input  logic                         branch_id,
  input  logic                         taken_id,
  input  logic                         mdu_op_id,
  input  logic                         mdu_read_id,
  input  logic [LEN_REG_FILE_ADDR-1:0] reg_3_ex,
  input  logic                         reg_write_ex,
  input  logic                         mem_read_ex,
  input  logic [LEN_REG_FILE_ADDR-1:0] reg_3_m,
  input  logic                         mem_read_m,
  output logic                         stall_pc,
  output logic                         stall_if_id,
  output logic                         bubble_id_ex,
  output logic                         flush_if_id,
  output logic                         mdu_start,
  output logic                         mdu_busy,
  output logic [31:0]                  stall_cycles
);

  typedef enum logic {IDLE, BUSY} mdu_state_e;

  mdu_state_e               state_q, state_d;
  logic [LEN_MDU_CNT-1:0]   cnt_q, cnt_d;
  logic [LEN_STALL_CNT-1:0] stall_cnt_q, stall_cnt_d;

  logic match_ex, match_m;
  logic load_use, br_ex, br_load_m, mdu_hz;
  logic stall;

  // r0 is hardwired zero, so a write to it never creates a dependency
  assign match_ex = (reg_3_ex != '0) &&
                    ((uses_reg_1_id && (reg_3_ex == reg_1_id)) ||
                     (uses_reg_2_id && (reg_3_ex == reg_2_id)));
  assign match_m  = (reg_3_m != '0) &&
                    ((uses_reg_1_id && (reg_3_m == reg_1_id)) ||
                     (uses_reg_2_id && (reg_3_m == reg_2_id)));

  assign load_use  = mem_read_ex && match_ex;
  assign br_ex     = branch_id && reg_write_ex && match_ex;
  assign br_load_m = branch_id && mem_read_m && match_m;
  assign mdu_hz    = (cnt_q != '0) && (mdu_op_id || mdu_read_id);

  assign stall = !reset && (load_use || br_ex || br_load_m || mdu_hz);

  assign stall_pc     = stall;
  assign stall_if_id  = stall;
  assign bubble_id_ex = stall;
  assign flush_if_id  = !reset && branch_id && taken_id && !stall;
  assign mdu_start    = !reset && mdu_op_id && !stall;
  assign mdu_busy     = !reset && (cnt_q != '0);
  assign stall_cycles = 32'(stall_cnt_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (mdu_start) begin
          cnt_d   = LEN_MDU_CNT'(MDU_LATENCY);
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - LEN_MDU_CNT'(1);
        if (cnt_q == LEN_MDU_CNT'(1)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + LEN_STALL_CNT'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb/tb_hazard_stall_controller.sv - directed checks of hazard stall controller
module tb_hazard_stall_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] reg_1_id, reg_2_id, reg_3_ex, reg_3_m;
  logic       uses_reg_1_id, uses_reg_2_id, branch_id, taken_id;
  logic       mdu_op_id, mdu_read_id, reg_write_ex, mem_read_ex, mem_read_m;

  logic        stall_pc, stall_if_id, bubble_id_ex, flush_if_id, mdu_start, mdu_busy;
  logic [31:0] stall_cycles;
  logic        n_stall_pc, n_stall_if_id, n_bubble_id_ex, n_flush_if_id, n_mdu_start, n_mdu_busy;
  logic [31:0] n_stall_cycles;

  logic [5:0] outs, n_outs;
  assign outs   = {stall_pc, stall_if_id, bubble_id_ex, flush_if_id, mdu_start, mdu_busy};
  assign n_outs = {n_stall_pc, n_stall_if_id, n_bubble_id_ex, n_flush_if_id, n_mdu_start, n_mdu_busy};

  int n_checks = 0;
  int n_fail   = 0;
  int exp_sc   = 0;

  always #5 clk = ~clk;

  hazard_stall_controller dut (
    .clk(clk), .reset(reset),
    .reg_1_id(reg_1_id), .reg_2_id(reg_2_id),
    .uses_reg_1_id(uses_reg_1_id), .uses_reg_2_id(uses_reg_2_id),
    .branch_id(branch_id), .taken_id(taken_id),
    .mdu_op_id(mdu_op_id), .mdu_read_id(mdu_read_id),
    .reg_3_ex(reg_3_ex), .reg_write_ex(reg_write_ex), .mem_read_ex(mem_read_ex),
    .reg_3_m(reg_3_m), .mem_read_m(mem_read_m),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id), .bubble_id_ex(bubble_id_ex),
    .flush_if_id(flush_if_id), .mdu_start(mdu_start), .mdu_busy(mdu_busy),
    .stall_cycles(stall_cycles)
  );

  hazard_stall_controller #(.LEN_STALL_CNT(4)) dut_narrow (
    .clk(clk), .reset(reset),
    .reg_1_id(reg_1_id), .reg_2_id(reg_2_id),
    .uses_reg_1_id(uses_reg_1_id), .uses_reg_2_id(uses_reg_2_id),
    .branch_id(branch_id), .taken_id(taken_id),
    .mdu_op_id(mdu_op_id), .mdu_read_id(mdu_read_id),
    .reg_3_ex(reg_3_ex), .reg_write_ex(reg_write_ex), .mem_read_ex(mem_read_ex),
    .reg_3_m(reg_3_m), .mem_read_m(mem_read_m),
    .stall_pc(n_stall_pc), .stall_if_id(n_stall_if_id), .bubble_id_ex(n_bubble_id_ex),
    .flush_if_id(n_flush_if_id), .mdu_start(n_mdu_start), .mdu_busy(n_mdu_busy),
    .stall_cycles(n_stall_cycles)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    reg_1_id = '0; reg_2_id = '0; reg_3_ex = '0; reg_3_m = '0;
    uses_reg_1_id = 0; uses_reg_2_id = 0; branch_id = 0; taken_id = 0;
    mdu_op_id = 0; mdu_read_id = 0; reg_write_ex = 0; mem_read_ex = 0; mem_read_m = 0;
  endtask

  task automatic set_load_use();
    clear_inputs();
    mem_read_ex = 1; reg_write_ex = 1; reg_3_ex = 5; reg_1_id = 5; uses_reg_1_id = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    tick();
    tick();
    n_checks++;
    if (stall_cycles !== 32'd0) begin
      n_fail++; $display("FAIL reset_sc got %0d exp 0", stall_cycles);
    end
    set_load_use();
    branch_id = 1; taken_id = 1; mdu_op_id = 1;
    #1;
    n_checks++;
    if (outs !== 6'b000000) begin
      n_fail++; $display("FAIL reset_outs_forced got %b exp 000000", outs);
    end
    clear_inputs();
    reset = 0;
    tick();
    n_checks++;
    if (outs !== 6'b000000 || stall_cycles !== 32'd0) begin
      n_fail++; $display("FAIL post_reset got outs=%b sc=%0d exp 000000 sc=0", outs, stall_cycles);
    end
  endtask

  task automatic test_load_use();
    set_load_use();
    #1;
    n_checks++;
    if (outs !== 6'b111000) begin
      n_fail++; $display("FAIL load_use got %b exp 111000", outs);
    end
    tick();
    exp_sc += 1;
    clear_inputs();
    #1;
    n_checks++;
    if (outs !== 6'b000000 || stall_cycles !== 32'(exp_sc)) begin
      n_fail++; $display("FAIL load_use_after got outs=%b sc=%0d exp 000000 sc=%0d", outs, stall_cycles, exp_sc);
    end
    set_load_use();
    uses_reg_1_id = 0;
    reg_2_id = 5;
    #1;
    n_checks++;
    if (outs !== 6'b000000) begin
      n_fail++; $display("FAIL load_use_unused_src got %b exp 000000", outs);
    end
    tick();
  endtask

  task automatic test_zero_reg();
    set_load_use();
    reg_3_ex = 0; reg_1_id = 0; branch_id = 1; taken_id = 1;
    #1;
    n_checks++;
    if (outs !== 6'b000100) begin
      n_fail++; $display("FAIL zero_reg_taken got %b exp 000100", outs);
    end
    taken_id = 0;
    #1;
    n_checks++;
    if (outs !== 6'b000000) begin
      n_fail++; $display("FAIL zero_reg_not_taken got %b exp 000000", outs);
    end
    tick();
    n_checks++;
    if (stall_cycles !== 32'(exp_sc)) begin
      n_fail++; $display("FAIL zero_reg_sc got %0d exp %0d", stall_cycles, exp_sc);
    end
  endtask

  task automatic test_branch();
    clear_inputs();
    branch_id = 1; taken_id = 1; reg_2_id = 8; uses_reg_2_id = 1;
    reg_3_ex = 8; reg_write_ex = 1; mem_read_ex = 1;
    #1;
    n_checks++;
    if (outs !== 6'b111000) begin
      n_fail++; $display("FAIL br_load_ex got %b exp 111000", outs);
    end
    tick();
    reg_3_ex = 0; reg_write_ex = 0; mem_read_ex = 0; reg_3_m = 8; mem_read_m = 1;
    #1;
    n_checks++;
    if (outs !== 6'b111000) begin
      n_fail++; $display("FAIL br_load_m got %b exp 111000", outs);
    end
    tick();
    reg_3_m = 0; mem_read_m = 0;
    #1;
    n_checks++;
    if (outs !== 6'b000100) begin
      n_fail++; $display("FAIL br_load_release got %b exp 000100", outs);
    end
    tick();
    exp_sc += 2;
    reg_3_ex = 8; reg_write_ex = 1;
    #1;
    n_checks++;
    if (outs !== 6'b111000 || stall_cycles !== 32'(exp_sc)) begin
      n_fail++; $display("FAIL br_alu_ex got outs=%b sc=%0d exp 111000 sc=%0d", outs, stall_cycles, exp_sc);
    end
    tick();
    exp_sc += 1;
    reg_3_ex = 0; reg_write_ex = 0; reg_3_m = 8;
    #1;
    n_checks++;
    if (outs !== 6'b000100) begin
      n_fail++; $display("FAIL br_alu_m_forwarded got %b exp 000100", outs);
    end
    tick();
  endtask

  task automatic test_mdu();
    clear_inputs();
    mdu_op_id = 1;
    #1;
    n_checks++;
    if (outs !== 6'b000010) begin
      n_fail++; $display("FAIL mdu_start got %b exp 000010", outs);
    end
    tick();
    mdu_op_id = 0; mdu_read_id = 1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      n_checks++;
      if (outs !== 6'b111001) begin
        n_fail++; $display("FAIL mdu_mflo_stall T+%0d got %b exp 111001", i, outs);
      end
      tick();
    end
    exp_sc += 4;
    n_checks++;
    if (outs !== 6'b000000 || stall_cycles !== 32'(exp_sc)) begin
      n_fail++; $display("FAIL mdu_mflo_issue got outs=%b sc=%0d exp 000000 sc=%0d", outs, stall_cycles, exp_sc);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    mdu_op_id = 1;
    tick();
    for (int i = 1; i <= 4; i++) begin
      #1;
      n_checks++;
      if (outs !== 6'b111001) begin
        n_fail++; $display("FAIL b2b_stall T+%0d got %b exp 111001", i, outs);
      end
      tick();
    end
    exp_sc += 4;
    n_checks++;
    if (outs !== 6'b000010) begin
      n_fail++; $display("FAIL b2b_second_start got %b exp 000010", outs);
    end
    tick();
    clear_inputs();
    #1;
    n_checks++;
    if (outs !== 6'b000001) begin
      n_fail++; $display("FAIL b2b_second_busy got %b exp 000001", outs);
    end
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if (outs !== 6'b000000 || stall_cycles !== 32'(exp_sc)) begin
      n_fail++; $display("FAIL b2b_idle got outs=%b sc=%0d exp 000000 sc=%0d", outs, stall_cycles, exp_sc);
    end
  endtask

  task automatic test_reset_mid_op();
    clear_inputs();
    mdu_op_id = 1;
    tick();
    mdu_op_id = 0;
    tick();
    reset = 1;
    set_load_use();
    mdu_read_id = 1; branch_id = 1; taken_id = 1;
    #1;
    n_checks++;
    if (outs !== 6'b000000) begin
      n_fail++; $display("FAIL reset_mid_op_outs got %b exp 000000", outs);
    end
    tick();
    reset = 0;
    clear_inputs();
    exp_sc = 0;
    #1;
    n_checks++;
    if (outs !== 6'b000000 || stall_cycles !== 32'd0) begin
      n_fail++; $display("FAIL reset_mid_op_after got outs=%b sc=%0d exp 000000 sc=0", outs, stall_cycles);
    end
    mdu_op_id = 1;
    #1;
    n_checks++;
    if (outs !== 6'b000010) begin
      n_fail++; $display("FAIL reset_mid_op_restart got %b exp 000010", outs);
    end
    tick();
    clear_inputs();
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_saturation();
    clear_inputs();
    reset = 1;
    tick();
    reset = 0;
    exp_sc = 0;
    set_load_use();
    for (int i = 0; i < 14; i++) begin
      #1;
      n_checks++;
      if (n_outs !== 6'b111000) begin
        n_fail++; $display("FAIL sat_stall_%0d got %b exp 111000", i, n_outs);
      end
      tick();
    end
    exp_sc = 14;
    n_checks++;
    if (n_stall_cycles !== 32'd14) begin
      n_fail++; $display("FAIL sat_below_max got %0d exp 14", n_stall_cycles);
    end
    tick();
    exp_sc++;
    n_checks++;
    if (n_stall_cycles !== 32'd15) begin
      n_fail++; $display("FAIL sat_at_max got %0d exp 15", n_stall_cycles);
    end
    for (int i = 0; i < 3; i++) tick();
    exp_sc += 3;
    n_checks++;
    if (n_stall_cycles !== 32'd15) begin
      n_fail++; $display("FAIL sat_hold got %0d exp 15", n_stall_cycles);
    end
    n_checks++;
    if (stall_cycles !== 32'(exp_sc)) begin
      n_fail++; $display("FAIL sat_wide_count got %0d exp %0d", stall_cycles, exp_sc);
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_zero_reg();
    test_branch();
    test_mdu();
    test_back_to_back();
    test_reset_mid_op();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
